// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad port: button bit positions
// in the 4021 shift order and the read-count saturation value.
package nes_joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int READS_PER_FRAME = 8;
  localparam int COUNT_W         = 4;

  localparam logic [COUNT_W-1:0] READ_SAT = COUNT_W'(READS_PER_FRAME);

endpackage

// File: rtl/nes_joypad_port_if.sv
// CPU-side bus of one joypad port: strobe level and read pulse from the
// CPU, serial data bit and read counter back to it.
interface nes_joypad_port_if;
  import nes_joypad_pkg::*;

  logic               strobe_in;
  logic               read_pulse;
  logic               data_out;
  logic [COUNT_W-1:0] read_count;

  modport master (
    output strobe_in,
    output read_pulse,
    input  data_out,
    input  read_count
  );

  modport slave (
    input  strobe_in,
    input  read_pulse,
    output data_out,
    output read_count
  );

endinterface

// File: rtl/joypad_turbo_gen.sv
// Free-running turbo divider. turbo_phase flips once every
// 2^TURBO_DIV_BITS clocks and starts high so turbo buttons initially pass.
module joypad_turbo_gen #(
  parameter int TURBO_DIV_BITS = 19
) (
  input  logic clk,
  input  logic rst_n,
  output logic turbo_phase
);

  logic [TURBO_DIV_BITS-1:0] div_count;

  // Divider counts every clock; the phase toggles on the all-ones count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_count   <= '0;
      turbo_phase <= 1'b1;
    end else begin
      div_count <= div_count + 1'b1;
      if (&div_count) begin
        turbo_phase <= ~turbo_phase;
      end
    end
  end

endmodule

// File: rtl/nes_joypad_port.sv
// One emulated NES controller: applies turbo on A/B and optional
// opposite-direction masking, then serialises the result 4021-style.
module nes_joypad_port
  import nes_joypad_pkg::*;
#(
  parameter int TURBO_DIV_BITS = 19,
  parameter bit DPAD_MASK      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               buttons_in,
  input  logic [1:0]               turbo_en,
  nes_joypad_port_if.slave         bus
);

  logic               turbo_phase;
  logic [7:0]         eff;
  logic [7:0]         shift_reg;
  logic [COUNT_W-1:0] count;

  joypad_turbo_gen #(
    .TURBO_DIV_BITS(TURBO_DIV_BITS)
  ) u_turbo (
    .clk        (clk),
    .rst_n      (rst_n),
    .turbo_phase(turbo_phase)
  );

  // Effective button vector: turbo gating on A/B, then D-pad masking.
  always_comb begin
    eff         = buttons_in;
    eff[BTN_A]  = buttons_in[BTN_A] & (~turbo_en[0] | turbo_phase);
    eff[BTN_B]  = buttons_in[BTN_B] & (~turbo_en[1] | turbo_phase);
    if (DPAD_MASK) begin
      if (buttons_in[BTN_UP] && buttons_in[BTN_DOWN]) begin
        eff[BTN_UP]   = 1'b0;
        eff[BTN_DOWN] = 1'b0;
      end
      if (buttons_in[BTN_LEFT] && buttons_in[BTN_RIGHT]) begin
        eff[BTN_LEFT]  = 1'b0;
        eff[BTN_RIGHT] = 1'b0;
      end
    end
  end

  // Strobe high reloads the snapshot every clock; otherwise each read shifts
  // right with 1s filling in, so reads past the eighth return 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
      count     <= '0;
    end else if (bus.strobe_in) begin
      shift_reg <= eff;
      count     <= '0;
    end else if (bus.read_pulse) begin
      shift_reg <= {1'b1, shift_reg[7:1]};
      if (count != READ_SAT) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.data_out   = shift_reg[0];
  assign bus.read_count = count;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Testbench for nes_joypad_port: two instances (D-pad mask on and off) with a
// short turbo divider, checked against a snapshot/read-index model.
module tb_nes_joypad_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic [1:0] turbo = 2'b00;
  logic       strobe = 1'b0;
  logic       rpulse = 1'b0;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  logic [7:0] snap_m = 8'h00;
  logic [7:0] snap_n = 8'h00;
  int         reads = 0;

  nes_joypad_port_if jp_m ();
  nes_joypad_port_if jp_n ();

  assign jp_m.strobe_in  = strobe;
  assign jp_m.read_pulse = rpulse;
  assign jp_n.strobe_in  = strobe;
  assign jp_n.read_pulse = rpulse;

  nes_joypad_port #(.TURBO_DIV_BITS(3), .DPAD_MASK(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .buttons_in(buttons), .turbo_en(turbo), .bus(jp_m)
  );

  nes_joypad_port #(.TURBO_DIV_BITS(3), .DPAD_MASK(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .buttons_in(buttons), .turbo_en(turbo), .bus(jp_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_eff(input logic [7:0] b, input logic [1:0] te,
                                           input logic ph, input bit mask);
    logic [7:0] r;
    r = b;
    if (te[0] && !ph) r[0] = 1'b0;
    if (te[1] && !ph) r[1] = 1'b0;
    if (mask && b[4] && b[5]) begin r[4] = 1'b0; r[5] = 1'b0; end
    if (mask && b[6] && b[7]) begin r[6] = 1'b0; r[7] = 1'b0; end
    return r;
  endfunction

  function automatic logic exp_bit(input logic [7:0] s, input int n);
    return (n < 8) ? s[n] : 1'b1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] c;
    c = (reads > 8) ? 4'd8 : 4'(reads);
    check({tag, "/m.data"},  {7'b0, jp_m.data_out}, {7'b0, exp_bit(snap_m, reads)});
    check({tag, "/m.count"}, {4'b0, jp_m.read_count}, {4'b0, c});
    check({tag, "/n.data"},  {7'b0, jp_n.data_out}, {7'b0, exp_bit(snap_n, reads)});
    check({tag, "/n.count"}, {4'b0, jp_n.read_count}, {4'b0, c});
  endtask

  // One clock: update the model from the inputs present at the edge, then check.
  task automatic tick(input string tag);
    logic ph;
    ph = ((edge_cnt / 8) % 2) == 0;
    if (strobe) begin
      snap_m = model_eff(buttons, turbo, ph, 1'b1);
      snap_n = model_eff(buttons, turbo, ph, 1'b0);
      reads  = 0;
    end else if (rpulse) begin
      reads++;
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    compare_all(tag);
  endtask

  task automatic model_reset();
    snap_m = 8'h00;
    snap_n = 8'h00;
    reads  = 0;
  endtask

  initial begin
    int seq[10];
    seq = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};

    // Reset state, before any clock edge.
    #1;
    model_reset();
    compare_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_cnt = 0;

    // A+Start snapshot, ten reads.
    buttons = 8'b0000_1001;
    strobe = 1'b1;
    tick("astart_load");
    strobe = 1'b0;
    rpulse = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("astart_seq", {7'b0, jp_m.data_out}, 8'(seq[i]));
      tick("astart_read");
    end
    rpulse = 1'b0;
    check("astart_final_count", {4'b0, jp_m.read_count}, 8'd8);

    // Up+Down: masked instance reads all 0, unmasked sees bits 4 and 5.
    buttons = 8'b0011_0000;
    strobe = 1'b1;
    tick("updown_load");
    strobe = 1'b0;
    rpulse = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("updown_mask", {7'b0, jp_m.data_out}, 8'h00);
      check("updown_nomask", {7'b0, jp_n.data_out}, (i == 4 || i == 5) ? 8'h01 : 8'h00);
      tick("updown_read");
    end
    rpulse = 1'b0;

    // Left+Right masking.
    buttons = 8'b1100_0101;
    strobe = 1'b1;
    tick("leftright_load");
    strobe = 1'b0;
    rpulse = 1'b1;
    for (int i = 0; i < 8; i++) tick("leftright_read");
    rpulse = 1'b0;

    // Turbo on A with strobe held: A toggles in blocks of eight clocks.
    turbo = 2'b01;
    buttons = 8'b0000_0001;
    strobe = 1'b1;
    for (int i = 0; i < 20; i++) tick("turbo_a");
    turbo = 2'b10;
    buttons = 8'b0000_0011;
    for (int i = 0; i < 20; i++) tick("turbo_b");
    turbo = 2'b00;

    // Strobe held, A toggles, read pulses ignored and count stays 0.
    rpulse = 1'b1;
    for (int i = 0; i < 6; i++) begin
      buttons = {7'b0, i[0]};
      tick("strobe_held");
    end
    rpulse = 1'b0;

    // Three reads, then buttons change mid-sequence; snapshot holds.
    buttons = 8'b0101_1010;
    tick("snap_load");
    strobe = 1'b0;
    rpulse = 1'b1;
    for (int i = 0; i < 3; i++) tick("snap_read3");
    buttons = 8'hFF;
    for (int i = 0; i < 5; i++) tick("snap_read5");
    rpulse = 1'b0;
    strobe = 1'b1;
    tick("ff_load");
    strobe = 1'b0;
    rpulse = 1'b1;
    for (int i = 0; i < 8; i++) tick("ff_read");
    rpulse = 1'b0;

    // Async reset after four reads.
    buttons = 8'b0000_1111;
    strobe = 1'b1;
    tick("rst_load");
    strobe = 1'b0;
    rpulse = 1'b1;
    for (int i = 0; i < 4; i++) tick("rst_read");
    rpulse = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all("async_reset");
    rst_n = 1'b1;
    edge_cnt = 0;
    tick("post_reset_idle");
    rpulse = 1'b1;
    for (int i = 0; i < 3; i++) tick("post_reset_read");
    rpulse = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      buttons = 8'($urandom);
      turbo   = 2'($urandom);
      strobe  = ($urandom_range(0, 5) == 0);
      rpulse  = ($urandom_range(0, 2) != 0);
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nes_joypad_port.md
# nes_joypad_port

Emulates one standard NES controller (4021-style parallel-in/serial-out shift register) on the CPU side of the $4016/$4017 joypad ports. Consumes the debounced, active-high button vector from the button debounce stage; serialises it to the CPU under strobe/read control. Adds per-button turbo on A/B and D-pad opposite-direction masking. One instance per player.

## Interface
- `TURBO_DIV_BITS`, 19: turbo divider width; turbo phase toggles every 2^TURBO_DIV_BITS clocks (≈23.8 Hz full period at 25 MHz).
- `DPAD_MASK`, 1'b1: 1 = Up+Down or Left+Right both pressed reports both released.
- `clk`  in  1  system clock; single clock domain; all inputs synchronous to it.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `buttons_in`  in  8  debounced buttons, 1 = pressed; bit order A,B,Select,Start,Up,Down,Left,Right (bit 0 = A).
- `turbo_en`  in  2  bit 0 = turbo A, bit 1 = turbo B.
- `strobe_in`  in  1  level of CPU-written $4016 bit 0.
- `read_pulse`  in  1  one-cycle pulse per CPU read of this port.
- `data_out`  out  1  current serial bit, 1 = pressed (CPU D0 before any bus inversion).
- `read_count`  out  4  reads since last strobe, saturating at 8.

## Operation
- Turbo: free-running divider counts every clock; on all-ones, `turbo_phase` toggles. Effective A = `buttons_in[0] & (~turbo_en[0] | turbo_phase)`; B likewise with bit 1.
- D-pad mask (DPAD_MASK=1): Up&Down both 1 → both 0; Left&Right both 1 → both 0. Other bits pass through.
- `eff` = effective 8-bit vector after turbo and mask (combinational).
- `strobe_in`=1: shift register loads `eff` every clock; `read_count` cleared to 0; `read_pulse` ignored (load wins).
- `strobe_in`=0: register holds snapshot from last strobe-high clock. On `read_pulse`: shift right one, bit 7 filled with 1; `read_count` increments, saturating at 8.
- `data_out` = shift register bit 0 (register output, no combinational path from inputs).
- After 8 reads `data_out` = 1 for every further read (official-controller behaviour).
- Strobe falling edge mid-sequence: no special action; next strobe high restarts.

## Timing
- Reset (async assert, sync release): shift register 8'h00, `data_out` 0, `read_count` 0, divider 0, `turbo_phase` 1 (turbo initially passes button).
- Load latency: `eff` captured at the clock edge where `strobe_in`=1; `data_out` shows A one clock later.
- CPU samples `data_out` in or before the cycle `read_pulse` is high; shift visible on `data_out` the clock after the pulse.
- Back-to-back `read_pulse` on consecutive clocks: each shifts once.
- `read_pulse` and `strobe_in` both 1 in same clock: load only, count 0.
- Button change while `strobe_in`=0: no effect until next strobe.
- Divider wrap and load in the same clock: load uses pre-toggle `turbo_phase`.
- `rst_n` low mid-sequence: immediate clear to reset values; resumes only on a new strobe.

## Structure
- Package `nes_joypad_pkg`: button index constants BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7; READS_PER_FRAME=8.
- Sub-module `joypad_turbo_gen` (divider + `turbo_phase`, params TURBO_DIV_BITS). Mask, shift register and counter in top.

## Test plan
- Reset, then strobe 1→0 with buttons_in=8'b0000_1001 (A+Start), 10 read pulses → data_out sequence 1,0,0,1,0,0,0,0,1,1; read_count ends 8.
- buttons_in=8'b0011_0000 (Up+Down), DPAD_MASK=1, strobe, 8 reads → all 0; DPAD_MASK=0 → bits 4,5 read 1.
- turbo_en=2'b01, A held, TURBO_DIV_BITS=3: strobe+read bit0 every clock → A alternates 1 for 8 clocks, 0 for 8 clocks.
- Strobe held 1, buttons_in toggles A each clock, read_pulse asserted → data_out follows A with 1-clock lag, read_count stays 0.
- Strobe, 3 reads, change buttons_in to 8'hFF → remaining 5 bits from old snapshot; new strobe → reads 8'hFF.
- rst_n low after 4 reads → data_out 0, read_count 0 immediately (async), no shift until next strobe.
